bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   Sits directly upstream of the 4-digit seven-segment output unit.
//   Turns the calculator's unsigned binary result into four packed BCD digits
//   on its 16-bit switch/data bus.
//   The result register holds steady between conversions, so the display never flickers.
// PARAMETERS
//   IN_WIDTH  14  width of binary input; 14 bits covers 0..16383
//   DIGITS    4   number of BCD digits presented; output width = 4*DIGITS
// PORTS
//   clock  in   1           system clock; all state changes on rising edge
//   reset  in   1           asynchronous, active-high; clears all state
//   start  in   1           request conversion of bin; sampled only in IDLE
//   bin    in   IN_WIDTH    unsigned binary value; sampled on the accepting edge only
//   busy   out  1           high while a conversion is in progress
//   done   out  1           one-cycle pulse: BCD/ovf updated this cycle
//   ovf    out  1           last result exceeded 10**DIGITS-1
//   BCD    out  4*DIGITS    packed digits, [3:0]=ones ... [15:12]=thousands
// BEHAVIOUR
//   Reset (async, any time, incl. mid-conversion):
//   - state=IDLE; busy=0, done=0, ovf=0, BCD=0.
//   - Any partial result is discarded.
//   FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE:
//   - Edge k with start=1:
//     - load scratch = {4*(DIGITS+1) zeros, bin};
//     - bitcnt = IN_WIDTH;
//     - ovf_next = (bin > 10**DIGITS-1);
//     - go to SHIFT.
//   - start=0: stay in IDLE.
//   SHIFT (edges k+1 .. k+IN_WIDTH):
//   - Per edge: every BCD nibble of scratch >= 5 gets +3, then scratch << 1.
//   - bitcnt decrements each edge; leave for DONE after the IN_WIDTH-th shift.
//   - The scratch BCD field is DIGITS+1 nibbles wide, so 16383 converts exactly.
//   DONE (entered at edge k+IN_WIDTH):
//   - At edge k+IN_WIDTH+1: BCD <= ovf_next ? ERR_PATTERN : low DIGITS nibbles.
//   - Same edge: ovf <= ovf_next; return to IDLE.
//   Outputs:
//   - busy=1 in SHIFT and DONE; combinational decode of state.
//   - done: registered; high exactly in the cycle after edge k+IN_WIDTH+1.
//     That is 15 clocks after acceptance for the default parameters.
//   - BCD and ovf change only together with done; otherwise they hold.
//   start while busy: ignored, not queued.
//   - A start in the same cycle as done is honoured, since the FSM is back in IDLE.
//   - Back-to-back conversions therefore cost IN_WIDTH+2 clocks each.
//   bin changing during SHIFT: no effect.
//   Widths:
//   - Overflow compare is done at IN_WIDTH+1 bits.
//   - The add-3 is done per nibble, with no carry between nibbles.
// STRUCTURE
//   Package calc_pkg:
//   - typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_t;
//   - localparam MAX_DISPLAY = 9999;
//   - localparam logic [15:0] ERR_PATTERN = 16'hEEEE.
//   The output unit renders ERR_PATTERN as "EEEE".
//   Sub-module bcd_add3 (4b in -> 4b out: in>=5 ? in+3 : in), combinational.
//   - Instantiated DIGITS+1 times via generate.
//   Counter width = $clog2(IN_WIDTH+1).
// TESTING
//   bin=1234, start pulse 1 clk:
//   - busy high next cycle;
//   - done 1 clk, 15 clks after start edge;
//   - BCD=16'h1234, ovf=0.
//   bin=0 -> BCD=16'h0000, ovf=0.
//   bin=9999 -> BCD=16'h9999, ovf=0.
//   bin=10000 -> BCD=16'hEEEE, ovf=1.
//   bin=16383 -> BCD=16'hEEEE, ovf=1.
//   Start 42, then at cycle 5 assert start with bin=77:
//   - only one done;
//   - BCD=16'h0042; second start ignored.
//   Start 555, assert reset at cycle 7:
//   - immediately busy=0, done=0, BCD=0000, ovf=0;
//   - after release, start 8 -> BCD=16'h0008 after 15 clks.
//   Back-to-back: start 321, re-assert start in the done cycle with bin=654:
//   - second done 16 clks after the first;
//   - BCD holds 16'h0321 between the two dones.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator datapath and its display path.
package calc_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_t;

    localparam int          MAX_DISPLAY = 9999;
    localparam logic [15:0] ERR_PATTERN = 16'hEEEE;

endpackage

// File: rtl/bcd_add3.sv
// One shift-and-add-3 correction cell: nibbles of 5 or more get +3 before the next shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock, result held between conversions.
//
//   state | meaning
//   IDLE  | waiting for start; bin and overflow flag captured on the accepting edge
//   SHIFT | one correct-and-shift step per clock, bitcnt counts down to 1
//   DONE  | publish BCD/ovf together with the done pulse, then back to IDLE
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int IN_WIDTH = 14,
    parameter int DIGITS   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   BCD
);

    localparam int BCD_W = 4 * (DIGITS + 1);
    localparam int SCR_W = BCD_W + IN_WIDTH;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam int OUT_W = 4 * DIGITS;

    localparam logic [IN_WIDTH:0] MAX_VAL = (IN_WIDTH + 1)'(10 ** DIGITS - 1);
    localparam logic [OUT_W-1:0]  ERR_VAL = {DIGITS{ERR_PATTERN[3:0]}};

    b2b_state_t         state;
    b2b_state_t         state_nxt;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   scratch_shf;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   bitcnt;
    logic               ovf_pend;

    // The extra top nibble lets the full input range convert without loss.
    for (genvar i = 0; i < DIGITS + 1; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch[IN_WIDTH + 4*i +: 4]),
            .dout (bcd_adj[4*i +: 4])
        );
    end

    assign scratch_shf = {bcd_adj, scratch[IN_WIDTH-1:0]} << 1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (bitcnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT) || (state == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch  <= '0;
            bitcnt   <= '0;
            ovf_pend <= 1'b0;
            BCD      <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        scratch  <= {{BCD_W{1'b0}}, bin};
                        bitcnt   <= CNT_W'(IN_WIDTH);
                        ovf_pend <= ({1'b0, bin} > MAX_VAL);
                    end
                end
                SHIFT: begin
                    scratch <= scratch_shf;
                    bitcnt  <= bitcnt - CNT_W'(1);
                end
                DONE: begin
                    BCD  <= ovf_pend ? ERR_VAL : scratch[IN_WIDTH +: OUT_W];
                    ovf  <= ovf_pend;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed literal cases plus randomized traffic vs a timing/value model.
module tb_bin2bcd_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin   = '0;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [15:0] BCD;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.IN_WIDTH(14), .DIGITS(4)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .BCD   (BCD)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        if (v > 9999) return 16'hEEEE;
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Model: a conversion accepted at edge k publishes its result at edge k+15.
    int          edge_n    = 0;
    int          done_edge = 0;
    bit          m_active  = 1'b0;
    bit          m_done    = 1'b0;
    bit          m_ovf     = 1'b0;
    bit          pend_ovf  = 1'b0;
    bit          was_idle  = 1'b1;
    logic [15:0] m_bcd     = '0;
    logic [15:0] pend_bcd  = '0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_bcd    = '0;
            m_ovf    = 1'b0;
            edge_n   = 0;
        end else begin
            edge_n++;
            was_idle = !m_active;
            m_done   = 1'b0;
            if (m_active && edge_n == done_edge) begin
                m_done   = 1'b1;
                m_bcd    = pend_bcd;
                m_ovf    = pend_ovf;
                m_active = 1'b0;
            end
            if (was_idle && start) begin
                m_active  = 1'b1;
                done_edge = edge_n + 15;
                pend_bcd  = ref_bcd(int'(bin));
                pend_ovf  = (int'(bin) > 9999);
            end
        end
    end

    always @(negedge clock) begin
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(m_done));
        chk("bcd",  32'(BCD),  32'(m_bcd));
        chk("ovf",  32'(ovf),  32'(m_ovf));
    end

    task automatic convert(input int val, input logic [15:0] exp_bcd, input logic exp_ovf,
                           input string tag);
        int lat;
        @(posedge clock);
        #2 start = 1'b1;
        bin = 14'(val);
        @(posedge clock);
        #1 chk({tag, "_busy_next"}, 32'(busy), 32'd1);
        #1 start = 1'b0;
        bin = 14'($urandom);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clock);
            #1 lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd15);
        chk({tag, "_bcd"}, 32'(BCD), 32'(exp_bcd));
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    endtask

    initial begin
        int ndone;
        int lat;
        logic [15:0] seen_bcd;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd",  32'(BCD),  32'h0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        #1 reset = 1'b0;

        convert(1234,  16'h1234, 1'b0, "c1234");
        convert(0,     16'h0000, 1'b0, "c0");
        convert(9999,  16'h9999, 1'b0, "c9999");
        convert(10000, 16'hEEEE, 1'b1, "c10000");
        convert(16383, 16'hEEEE, 1'b1, "c16383");
        convert(7,     16'h0007, 1'b0, "c7");

        // start while busy is dropped
        @(posedge clock);
        #2 start = 1'b1;
        bin = 14'd42;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (4) @(posedge clock);
        #2 start = 1'b1;
        bin = 14'd77;
        @(posedge clock);
        #2 start = 1'b0;
        ndone = 0;
        seen_bcd = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done) begin
                ndone++;
                seen_bcd = BCD;
            end
        end
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_bcd", 32'(seen_bcd), 32'h0042);

        // reset in the middle of a conversion
        @(posedge clock);
        #2 start = 1'b1;
        bin = 14'd555;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (6) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_bcd",  32'(BCD),  32'h0);
        chk("mid_rst_ovf",  32'(ovf),  32'd0);
        @(posedge clock);
        #2 reset = 1'b0;
        convert(8, 16'h0008, 1'b0, "after_rst");

        // back-to-back: restart in the done cycle
        convert(321, 16'h0321, 1'b0, "b2b_first");
        #1 start = 1'b1;
        bin = 14'd654;
        @(posedge clock);
        #1 lat = 1;
        start = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clock);
            #1 lat++;
            if (!done) chk("b2b_hold", 32'(BCD), 32'h0321);
        end
        chk("b2b_gap", 32'(lat), 32'd16);
        chk("b2b_second", 32'(BCD), 32'h0654);

        // randomized traffic, including starts while busy, edge values and rare resets
        for (int i = 0; i < 1500; i++) begin
            @(posedge clock);
            #2;
            start = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 7))
                0:       bin = 14'd9999;
                1:       bin = 14'd10000;
                2:       bin = 14'd16383;
                3:       bin = 14'd0;
                default: bin = 14'($urandom);
            endcase
            reset = ($urandom_range(0, 299) == 0);
        end
        @(posedge clock);
        #2 start = 1'b0;
        reset = 1'b0;
        repeat (20) @(posedge clock);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
